gf4_pow_seq: RTL and testbench
==============================

# gf4_pow_seq

Sequential GF(2^4) arithmetic unit that time-shares a single combinational GF(2^4) multiplier (field polynomial x^4 + x + 1) to compute either a single product a·b or an exponent a^e by square-and-multiply. It sits in the composite-field S-box path and supplies the GF(2^4) inverse as a^14, so the S-box needs no separate inverter table. Operands arrive on a valid/ready request port and results leave on a valid/ready response port.

## Interface
- No parameters; field width fixed at 4 bits, polynomial fixed at x^4 + x + 1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at a clk edge.
- in_op  in  1  0 = multiply (a·b), 1 = power (a^b).
- in_a  in  4  operand a / base.
- in_b  in  4  operand b / exponent e (unsigned 0..15).
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready at a clk edge.
- out_data  out  4  result.
- busy  out  1  high in BUSY and DONE.

## Operation
- One internal GF(2^4) multiplier instance; its operands are muxed from the registers below. No second multiplier.
- Registers: state, op, a, e, acc[3:0], step[2:0].
- States:
  - IDLE: in_ready = 1. On accept, latch op, a and e (e = in_b), set acc = 1 and step = 0, then go to BUSY.
  - BUSY: one multiply per edge.
    - op = 0: acc <= a·e, then go to DONE.
    - op = 1: process exponent bits MSB first over 8 steps; bit index i = 3 - step[2:1].
      - Even step: acc <= acc·acc.
      - Odd step: acc <= e[i] ? acc·a : acc. The multiply is issued every step, so latency does not depend on data.
      - After step 7, go to DONE.
  - DONE: out_valid = 1, out_data = acc. On out_ready, go to IDLE.
- in_ready = (state == IDLE). in_valid in BUSY or DONE is ignored; the requester holds its data until accepted.
- out_data and out_valid stay stable in DONE until out_ready.
- Arithmetic results:
  - Power with e = 0 returns 1 for every a, including a = 0.
  - 0^e = 0 for e ≥ 1.
  - Inverse = power with e = 14; inv(0) = 0.
- Reset (any state, including mid-BUSY): state = IDLE, acc = 0, step = 0, op/a/e = 0. Any operation in flight is abandoned and produces no output.

## Timing
- Values during and after reset: in_ready 1, out_valid 0, out_data 0, busy 0.
- Accept edge T0. BUSY occupies edges T1..Tn, with n = 1 for multiply and n = 8 for power. out_valid rises just after edge Tn.
- Multiply result is visible 2 edges after the accept edge; power result 9 edges after.
- Result handshake occurs at edge Tn+1 at the earliest. in_ready is high in the following cycle, so the next accept is possible at Tn+2.
- Sustained throughput with out_ready held high: 1 multiply per 3 cycles, 1 power per 10 cycles.
- out_valid and in_ready are never high in the same cycle.
- out_data is registered, not combinational from inputs. out_data = acc, so out_data is undefined-by-spec outside DONE and checked only while out_valid = 1.

## Test plan
- Reset: hold rst_n low, then release -> in_ready 1, out_valid 0, busy 0, out_data 0. Assert rst_n asynchronously mid-cycle -> outputs reset without waiting for clk.
- Multiply: (op 0, a 3, b 7) -> 9; (8, 8) -> 0xC; (2, 9) -> 1. out_valid rises exactly 2 edges after accept. Exhaustive 256 pairs against a reference model.
- Power: (op 1, a 2, e 14) -> 9; (2, 4) -> 3; (2, 15) -> 1; (0, 0) -> 1; (0, 14) -> 0; (5, 1) -> 5. out_valid rises exactly 9 edges after accept. For all a ≠ 0, multiplying a by pow(a, 14) gives 1.
- Backpressure: hold out_ready low 5 cycles in DONE while toggling in_valid and in_a -> out_data stable, out_valid 1, in_ready 0, no new accept. Raise out_ready -> handshake, then in_ready 1 the next cycle.
- Reset mid-operation: start power (2, 14) and assert rst_n at BUSY step 4 -> out_valid never rises for it. After release, (3, 7) multiply returns 9 with normal latency.
- Back-to-back: in_valid and out_ready held high over a stream of 20 mixed ops -> every result correct and in order, spacing 3 cycles for multiply and 10 for power, no request lost or duplicated.

Source files
------------

// File: rtl/gf4_pow_seq.sv
// ---------------------------------------------------------------------------
// gf4_pow_seq
//
// Sequential GF(2^4) arithmetic unit (field polynomial x^4 + x + 1).
// A single combinational GF(2^4) multiplier is time-shared to compute either
// one product a*b or the power a^e by MSB-first square-and-multiply.
// The composite-field S-box path uses the power mode with e = 14 to obtain
// the field inverse (inv(0) = 0 falls out naturally because 0^14 = 0).
//
// Ports
//   clk        in   1  clock, all state updates on the rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  request valid
//   in_ready   out  1  request accepted on in_valid && in_ready
//   in_op      in   1  0 = multiply (a*b), 1 = power (a^b)
//   in_a       in   4  operand a / base
//   in_b       in   4  operand b / exponent (0..15)
//   out_valid  out  1  result valid (held until out_ready)
//   out_ready  in   1  result consumed on out_valid && out_ready
//   out_data   out  4  result, registered
//   busy       out  1  high while an operation is in progress or waiting
//                      to be consumed
// ---------------------------------------------------------------------------
module gf4_pow_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_op,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic       op_reg,    op_next;
    logic [3:0] a_reg,     a_next;
    logic [3:0] e_reg,     e_next;
    logic [3:0] acc_reg,   acc_next;
    logic [2:0] step_reg,  step_next;

    // -----------------------------------------------------------------------
    // Shared multiplier operand selection.
    //   multiply      : a * e            (e holds operand b)
    //   power, even   : acc * acc        (square)
    //   power, odd    : acc * a          (conditional multiply)
    // The multiply is always evaluated; the odd step simply discards the
    // product when the exponent bit is zero, keeping latency data-independent.
    // -----------------------------------------------------------------------
    logic [3:0] mul_x;
    logic [3:0] mul_y;
    logic [3:0] mul_p;

    always_comb begin
        mul_x = a_reg;
        mul_y = e_reg;
        if (op_reg) begin
            mul_x = acc_reg;
            mul_y = step_reg[0] ? a_reg : acc_reg;
        end
    end

    // -----------------------------------------------------------------------
    // GF(2^4) multiplier: carry-less partial products, then fold the three
    // overflow bits back using x^4 = x+1, x^5 = x^2+x, x^6 = x^3+x^2.
    // -----------------------------------------------------------------------
    localparam logic [11:0] RED_TAB = {4'hC, 4'h6, 4'h3};

    logic [6:0] pp       [0:3];
    logic [6:0] prod_raw;
    logic [3:0] red_term [0:2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pp
            assign pp[gi] = mul_y[gi] ? ({3'b000, mul_x} << gi) : 7'd0;
        end
        for (genvar gi = 0; gi < 3; gi++) begin : g_red
            assign red_term[gi] = prod_raw[4 + gi] ? RED_TAB[gi*4 +: 4] : 4'h0;
        end
    endgenerate

    assign prod_raw = pp[0] ^ pp[1] ^ pp[2] ^ pp[3];
    assign mul_p    = prod_raw[3:0] ^ red_term[0] ^ red_term[1] ^ red_term[2];

    // Exponent bit consumed by the current square/multiply pair, MSB first.
    logic [1:0] bit_idx;
    logic       e_bit;

    assign bit_idx = 2'd3 - step_reg[2:1];
    assign e_bit   = e_reg[bit_idx];

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            op_reg    <= 1'b0;
            a_reg     <= 4'h0;
            e_reg     <= 4'h0;
            acc_reg   <= 4'h0;
            step_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            e_reg     <= e_next;
            acc_reg   <= acc_next;
            step_reg  <= step_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        e_next     = e_reg;
        acc_next   = acc_reg;
        step_next  = step_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    op_next    = in_op;
                    a_next     = in_a;
                    e_next     = in_b;
                    acc_next   = 4'h1;
                    step_next  = 3'd0;
                    state_next = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (!op_reg) begin
                    acc_next   = mul_p;
                    state_next = ST_DONE;
                end else begin
                    // Squares always land; the multiply-by-a lands only for
                    // a set exponent bit.
                    if (!step_reg[0] || e_bit) begin
                        acc_next = mul_p;
                    end
                    step_next = step_reg + 3'd1;
                    if (step_reg == 3'd7) begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: all decoded from registered state, nothing combinational from
    // the input ports.
    // -----------------------------------------------------------------------
    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign out_data  = acc_reg;

endmodule

// File: tb/tb_gf4_pow_seq.sv
// ---------------------------------------------------------------------------
// tb_gf4_pow_seq
//
// Directed bench for gf4_pow_seq. Accepted requests push their expected
// result onto a scoreboard queue; a monitor pops and compares at each result
// handshake and also checks the accept-to-valid latency.
// ---------------------------------------------------------------------------
module tb_gf4_pow_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    gf4_pow_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] exp;
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        int         acc_at;
    } item_t;

    item_t      q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    logic [3:0] last_out     = 4'h0;

    // Reference: shift-and-add multiply with reduction by 0x13.
    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [4:0] x;
        logic [3:0] y;
        r = 4'h0;
        x = {1'b0, a};
        y = b;
        for (int k = 0; k < 4; k++) begin
            if (y[0]) r = r ^ x[3:0];
            y = y >> 1;
            x = x << 1;
            if (x[4]) x = x ^ 5'h13;
        end
        return r;
    endfunction

    // Reference: power by repeated multiplication.
    function automatic logic [3:0] ref_pow(input logic [3:0] a, input logic [3:0] e);
        logic [3:0] r;
        r = 4'h1;
        for (int k = 0; k < int'(e); k++) r = ref_mul(r, a);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request with an explicit expected result; returns once accepted
    // (at posedge+1). in_valid is left high so callers can stream.
    task automatic issue_exp(input logic op, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] exp, output int acc_at);
        item_t it;
        logic  rdy;
        int    n;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        rdy      = 1'b0;
        for (n = 0; n < 40 && !rdy; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
        end
        acc_at = cyc;
        if (!rdy) begin
            chk("accept_timeout", 8'd0, 8'd1);
        end else begin
            it.exp    = exp;
            it.op     = op;
            it.a      = a;
            it.b      = b;
            it.acc_at = cyc;
            q.push_back(it);
        end
    endtask

    task automatic issue(input logic op, input logic [3:0] a, input logic [3:0] b,
                         output int acc_at);
        issue_exp(op, a, b, op ? ref_pow(a, b) : ref_mul(a, b), acc_at);
    endtask

    // Wait until every accepted request has been consumed.
    task automatic drain();
        int n;
        for (n = 0; n < 400 && q.size() != 0; n++) @(negedge clk);
        chk("drain_timeout", 8'(q.size()), 8'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency on out_valid rise, data at handshake.
    task automatic monitor();
        logic  prev_ov;
        item_t it;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_ov = 1'b0;
                continue;
            end
            if (out_valid) chk("ready_while_valid", in_ready, 1'b0);
            if (out_valid && !prev_ov) begin
                chk("spurious_output", (q.size() > 0), 1'b1);
                if (q.size() > 0) begin
                    it = q[0];
                    chk(it.op ? "pow_latency" : "mul_latency",
                        8'(cyc - it.acc_at), it.op ? 8'd9 : 8'd2);
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                it = q.pop_front();
                $display("[TB] op=%0d a=%0h b=%0h -> out=%0h exp=%0h",
                         it.op, it.a, it.b, out_data, it.exp);
                chk(it.op ? "pow_data" : "mul_data", out_data, it.exp);
                last_out = out_data;
            end
            prev_ov = out_valid;
        end
    endtask

    initial begin
        int         t;
        int         prev_t;
        logic       prev_op;
        logic       op;
        logic [3:0] inv;
        logic [3:0] ai;
        logic [3:0] bi;
        int         got;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_a      = 4'h0;
        in_b      = 4'h0;
        out_ready = 1'b1;

        fork
            monitor();
        join_none

        // Reset values while held and after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_out_data",  out_data,  4'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready",  in_ready,  1'b1);
        chk("rel_out_valid", out_valid, 1'b0);
        chk("rel_busy",      busy,      1'b0);
        chk("rel_out_data",  out_data,  4'h0);
        @(posedge clk);
        #1;

        // Directed multiplies (3*7=9, 8*8=C, 2*9=1).
        issue_exp(1'b0, 4'h3, 4'h7, 4'h9, t);
        issue_exp(1'b0, 4'h8, 4'h8, 4'hC, t);
        issue_exp(1'b0, 4'h2, 4'h9, 4'h1, t);
        in_valid = 1'b0;
        drain();

        // Directed powers.
        issue_exp(1'b1, 4'h2, 4'hE, 4'h9, t);
        issue_exp(1'b1, 4'h2, 4'h4, 4'h3, t);
        issue_exp(1'b1, 4'h2, 4'hF, 4'h1, t);
        issue_exp(1'b1, 4'h0, 4'h0, 4'h1, t);
        issue_exp(1'b1, 4'h0, 4'hE, 4'h0, t);
        issue_exp(1'b1, 4'h5, 4'h1, 4'h5, t);
        in_valid = 1'b0;
        drain();

        // Inverse property: a * a^14 == 1 for every nonzero a.
        for (int a = 1; a < 16; a++) begin
            issue(1'b1, 4'(a), 4'hE, t);
            in_valid = 1'b0;
            drain();
            inv = last_out;
            issue_exp(1'b0, 4'(a), inv, 4'h1, t);
            in_valid = 1'b0;
            drain();
        end

        // Backpressure: hold the result for 5 cycles while poking the input.
        out_ready = 1'b0;
        issue_exp(1'b0, 4'h3, 4'h7, 4'h9, t);
        in_valid = 1'b0;
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        chk("bp_valid_timeout", 8'(got), 8'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = (k % 2 == 0);
            in_a     = 4'(k + 10);
            @(negedge clk);
            chk("bp_out_data",  out_data,  4'h9);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready",  in_ready,  1'b0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_after_in_ready",  in_ready,  1'b1);
        chk("bp_after_out_valid", out_valid, 1'b0);
        chk("bp_no_extra_accept", 8'(q.size()), 8'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a power operation (at step 4).
        issue(1'b1, 4'h2, 4'hE, t);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy",      busy,      1'b0);
        chk("async_rst_in_ready",  in_ready,  1'b1);
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_out_data",  out_data,  4'h0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        issue_exp(1'b0, 4'h3, 4'h7, 4'h9, t);
        in_valid = 1'b0;
        drain();

        // Back-to-back mixed stream, in_valid and out_ready held high.
        prev_op = 1'b0;
        prev_t  = 0;
        for (int i = 0; i < 20; i++) begin
            op = (i % 3 != 0);
            ai = 4'((i * 7 + 3) & 15);
            bi = 4'((i * 5 + 1) & 15);
            issue(op, ai, bi, t);
            if (i > 0) chk("stream_spacing", 8'(t - prev_t), prev_op ? 8'd10 : 8'd3);
            prev_t  = t;
            prev_op = op;
        end
        in_valid = 1'b0;
        drain();

        // Exhaustive multiply against the reference model.
        for (int p = 0; p < 256; p++) begin
            issue(1'b0, 4'(p >> 4), 4'(p & 15), t);
        end
        in_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
